// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter:
// FSM state encoding and default bus/counter widths.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones, with count enable
// and synchronous clear (clear has priority).
module arb_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en && (cnt_r != ALL_ONES)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) sequencer for a single shared memory port.
// Define MEM_ARB_STATS_EN to add saturating per-port stall-cycle counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W  = ARB_CNT_W
`endif
) (
    input  logic              CLK_IN,
    input  logic              GLOBALRESET,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic [DATA_W-1:0] if_rdata_out,
    output logic              if_ready_out,
    output logic              if_stall_out,
    input  logic              dm_read_in,
    input  logic              dm_write_in,
    input  logic [ADDR_W-1:0] dm_addr_in,
    input  logic [DATA_W-1:0] dm_wdata_in,
    output logic [DATA_W-1:0] dm_rdata_out,
    output logic              dm_ready_out,
    output logic              dm_stall_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    input  logic              mem_ack_in
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  if_stall_cnt_out,
    output logic [CNT_W-1:0]  dm_stall_cnt_out
`endif
);

    arb_state_t        state_r, state_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
    logic [DATA_W-1:0] dm_rdata_r, dm_rdata_s;
    logic              if_ready_r, if_ready_s;
    logic              dm_ready_r, dm_ready_s;
    logic              if_stall_s, dm_stall_s;

    // A request whose ready pulse is showing is already served, so the stall
    // terms double as the grant candidates and block a duplicate re-issue.
    assign if_stall_s = if_req_in && !if_ready_r;
    assign dm_stall_s = (dm_read_in || dm_write_in) && !dm_ready_r;

    // Next-state and next registered-output logic.
    always_comb begin
        state_s     = state_r;
        mem_en_s    = mem_en_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        if_ready_s  = 1'b0;
        dm_ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_stall_s) begin
                    state_s     = DM_BUSY;
                    mem_en_s    = 1'b1;
                    mem_we_s    = dm_write_in;
                    mem_addr_s  = dm_addr_in;
                    mem_wdata_s = dm_wdata_in;
                end else if (if_stall_s) begin
                    state_s    = IF_BUSY;
                    mem_en_s   = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr_in;
                end else begin
                    state_s = IDLE;
                end
            end
            DM_BUSY: begin
                if (mem_ack_in) begin
                    state_s    = IDLE;
                    mem_en_s   = 1'b0;
                    dm_ready_s = 1'b1;
                    if (!mem_we_r) begin
                        dm_rdata_s = mem_rdata_in;
                    end else begin
                        dm_rdata_s = dm_rdata_r;
                    end
                end else begin
                    state_s = DM_BUSY;
                end
            end
            IF_BUSY: begin
                if (mem_ack_in) begin
                    state_s    = IDLE;
                    mem_en_s   = 1'b0;
                    if_ready_s = 1'b1;
                    if_rdata_s = mem_rdata_in;
                end else begin
                    state_s = IF_BUSY;
                end
            end
            default: begin
                state_s  = IDLE;
                mem_en_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK_IN) begin
        if (!GLOBALRESET) begin
            state_r     <= IDLE;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            dm_rdata_r  <= dm_rdata_s;
            if_ready_r  <= if_ready_s;
            dm_ready_r  <= dm_ready_s;
        end
    end

    assign mem_en_out    = mem_en_r;
    assign mem_we_out    = mem_we_r;
    assign mem_addr_out  = mem_addr_r;
    assign mem_wdata_out = mem_wdata_r;
    assign if_rdata_out  = if_rdata_r;
    assign dm_rdata_out  = dm_rdata_r;
    assign if_ready_out  = if_ready_r;
    assign dm_ready_out  = dm_ready_r;
    assign if_stall_out  = if_stall_s;
    assign dm_stall_out  = dm_stall_s;

`ifdef MEM_ARB_STATS_EN
    arb_sat_counter #(.WIDTH(CNT_W)) u_if_stall_cnt (
        .clk (CLK_IN),
        .clr (!GLOBALRESET),
        .en  (if_stall_s),
        .cnt (if_stall_cnt_out)
    );

    arb_sat_counter #(.WIDTH(CNT_W)) u_dm_stall_cnt (
        .clk (CLK_IN),
        .clr (!GLOBALRESET),
        .en  (dm_stall_s),
        .cnt (dm_stall_cnt_out)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and
// outputs sampled on the falling edge. Stats checks need MEM_ARB_STATS_EN.
module tb_mem_port_arbiter;

    logic        CLK_IN;
    logic        GLOBALRESET;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_rdata_out;
    logic        if_ready_out;
    logic        if_stall_out;
    logic        dm_read_in;
    logic        dm_write_in;
    logic [31:0] dm_addr_in;
    logic [31:0] dm_wdata_in;
    logic [31:0] dm_rdata_out;
    logic        dm_ready_out;
    logic        dm_stall_out;
    logic        mem_en_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;
`ifdef MEM_ARB_STATS_EN
    logic [2:0]  if_stall_cnt_out;
    logic [2:0]  dm_stall_cnt_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
`ifdef MEM_ARB_STATS_EN
        ,
        .CNT_W  (3)
`endif
    ) dut (
        .CLK_IN        (CLK_IN),
        .GLOBALRESET   (GLOBALRESET),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_rdata_out  (if_rdata_out),
        .if_ready_out  (if_ready_out),
        .if_stall_out  (if_stall_out),
        .dm_read_in    (dm_read_in),
        .dm_write_in   (dm_write_in),
        .dm_addr_in    (dm_addr_in),
        .dm_wdata_in   (dm_wdata_in),
        .dm_rdata_out  (dm_rdata_out),
        .dm_ready_out  (dm_ready_out),
        .dm_stall_out  (dm_stall_out),
        .mem_en_out    (mem_en_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdata_in  (mem_rdata_in),
        .mem_ack_in    (mem_ack_in)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_stall_cnt_out (if_stall_cnt_out),
        .dm_stall_cnt_out (dm_stall_cnt_out)
`endif
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic tick();
        @(negedge CLK_IN);
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Fetch with ack sampled on the ack_edge-th rising edge after the request.
    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data, input int ack_edge);
        if_req_in  = 1'b1;
        if_addr_in = addr;
        for (int i = 1; i < ack_edge; i++) tick();
        mem_ack_in   = 1'b1;
        mem_rdata_in = data;
        tick();
        mem_ack_in = 1'b0;
    endtask

    initial begin
        GLOBALRESET  = 1'b0;
        if_req_in    = 1'b1;
        if_addr_in   = 32'h0000_0004;
        dm_read_in   = 1'b1;
        dm_write_in  = 1'b1;
        dm_addr_in   = 32'h0000_0008;
        dm_wdata_in  = 32'h1111_1111;
        mem_rdata_in = 32'h2222_2222;
        mem_ack_in   = 1'b1;

        // Reset held two cycles with every request asserted
        tick();
        tick();
        check_value("rst_mem_en",   32'(mem_en_out),   32'd0);
        check_value("rst_mem_addr", mem_addr_out,      32'd0);
        check_value("rst_if_ready", 32'(if_ready_out), 32'd0);
        check_value("rst_dm_ready", 32'(dm_ready_out), 32'd0);
        check_value("rst_if_rdata", if_rdata_out,      32'd0);
        check_value("rst_dm_rdata", dm_rdata_out,      32'd0);
        check_value("rst_if_stall", 32'(if_stall_out), 32'd1);
        check_value("rst_dm_stall", 32'(dm_stall_out), 32'd1);
        GLOBALRESET = 1'b1;
        if_req_in   = 1'b0;
        dm_read_in  = 1'b0;
        dm_write_in = 1'b0;
        mem_ack_in  = 1'b0;
        tick();
        check_value("idle_mem_en", 32'(mem_en_out), 32'd0);

        // Single fetch, ack two cycles after mem_en rises
        if_req_in  = 1'b1;
        if_addr_in = 32'h0000_0040;
        tick();
        check_value("f_mem_en",   32'(mem_en_out),   32'd1);
        check_value("f_mem_addr", mem_addr_out,      32'h0000_0040);
        check_value("f_mem_we",   32'(mem_we_out),   32'd0);
        check_value("f_if_stall", 32'(if_stall_out), 32'd1);
        tick();
        check_value("f_hold_en",  32'(mem_en_out),   32'd1);
        check_value("f_no_ready", 32'(if_ready_out), 32'd0);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h8C02_0004;
        tick();
        mem_ack_in = 1'b0;
        check_value("f_if_ready", 32'(if_ready_out), 32'd1);
        check_value("f_if_rdata", if_rdata_out,      32'h8C02_0004);
        check_value("f_stall_lo", 32'(if_stall_out), 32'd0);
        check_value("f_en_lo",    32'(mem_en_out),   32'd0);
        if_req_in = 1'b0;
        tick();
        check_value("f_ready_pulse", 32'(if_ready_out), 32'd0);
        check_value("f_rdata_hold",  if_rdata_out,      32'h8C02_0004);

        // Contention: data granted first, fetch after one idle cycle
        if_req_in  = 1'b1;
        if_addr_in = 32'h0000_0080;
        dm_read_in = 1'b1;
        dm_addr_in = 32'h0000_0100;
        tick();
        check_value("c_dm_addr",  mem_addr_out,      32'h0000_0100);
        check_value("c_dm_we",    32'(mem_we_out),   32'd0);
        check_value("c_if_stall", 32'(if_stall_out), 32'd1);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h1234_5678;
        tick();
        mem_ack_in = 1'b0;
        check_value("c_dm_ready", 32'(dm_ready_out), 32'd1);
        check_value("c_dm_rdata", dm_rdata_out,      32'h1234_5678);
        check_value("c_gap_en",   32'(mem_en_out),   32'd0);
        check_value("c_if_stall2", 32'(if_stall_out), 32'd1);
        check_value("c_dm_stall", 32'(dm_stall_out), 32'd0);
        dm_read_in = 1'b0;
        tick();
        check_value("c_if_en",      32'(mem_en_out),   32'd1);
        check_value("c_if_addr",    mem_addr_out,      32'h0000_0080);
        check_value("c_dm_pulse",   32'(dm_ready_out), 32'd0);
        check_value("c_if_stall3",  32'(if_stall_out), 32'd1);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hAABB_CCDD;
        tick();
        mem_ack_in = 1'b0;
        check_value("c_if_ready", 32'(if_ready_out), 32'd1);
        check_value("c_if_rdata", if_rdata_out,      32'hAABB_CCDD);
        check_value("c_dm_keep",  dm_rdata_out,      32'h1234_5678);
        if_req_in = 1'b0;
        tick();

        // Store: address/data held until ack, load data untouched
        dm_write_in = 1'b1;
        dm_addr_in  = 32'h0000_0200;
        dm_wdata_in = 32'hDEAD_BEEF;
        tick();
        check_value("s_we",    32'(mem_we_out), 32'd1);
        check_value("s_addr",  mem_addr_out,    32'h0000_0200);
        check_value("s_wdata", mem_wdata_out,   32'hDEAD_BEEF);
        dm_addr_in  = 32'h0000_0000;
        dm_wdata_in = 32'h0000_0000;
        tick();
        tick();
        check_value("s_hold_en",    32'(mem_en_out), 32'd1);
        check_value("s_hold_addr",  mem_addr_out,    32'h0000_0200);
        check_value("s_hold_wdata", mem_wdata_out,   32'hDEAD_BEEF);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hFFFF_FFFF;
        tick();
        mem_ack_in = 1'b0;
        check_value("s_dm_ready", 32'(dm_ready_out), 32'd1);
        check_value("s_dm_rdata", dm_rdata_out,      32'h1234_5678);
        dm_write_in = 1'b0;
        tick();

        // Read and write together behave as a write
        dm_read_in  = 1'b1;
        dm_write_in = 1'b1;
        dm_addr_in  = 32'h0000_0204;
        dm_wdata_in = 32'h0BAD_F00D;
        tick();
        check_value("rw_we", 32'(mem_we_out), 32'd1);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h5555_5555;
        tick();
        mem_ack_in = 1'b0;
        check_value("rw_dm_rdata", dm_rdata_out, 32'h1234_5678);
        dm_read_in  = 1'b0;
        dm_write_in = 1'b0;
        tick();

        // Reset during DM_BUSY, then a late ack in IDLE
        dm_read_in = 1'b1;
        dm_addr_in = 32'h0000_0300;
        tick();
        check_value("r_busy_en", 32'(mem_en_out), 32'd1);
        GLOBALRESET = 1'b0;
        tick();
        check_value("r_abort_en",    32'(mem_en_out),   32'd0);
        check_value("r_abort_ready", 32'(dm_ready_out), 32'd0);
        GLOBALRESET  = 1'b1;
        dm_read_in   = 1'b0;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h7777_7777;
        tick();
        mem_ack_in = 1'b0;
        check_value("r_late_ready", 32'(dm_ready_out), 32'd0);
        check_value("r_late_en",    32'(mem_en_out),   32'd0);
        check_value("r_late_rdata", dm_rdata_out,      32'd0);
        check_value("r_late_addr",  mem_addr_out,      32'd0);
        tick();
        check_value("r_idle_ready", 32'(dm_ready_out), 32'd0);
        check_value("r_if_ready",   32'(if_ready_out), 32'd0);

`ifdef MEM_ARB_STATS_EN
        // Five-cycle fetch stall, then a ten-cycle stall saturating at 7
        GLOBALRESET = 1'b0;
        tick();
        GLOBALRESET = 1'b1;
        tick();
        check_value("st_clear", 32'(if_stall_cnt_out), 32'd0);
        run_fetch(32'h0000_0044, 32'h0000_0001, 5);
        check_value("st_if_cnt5", 32'(if_stall_cnt_out), 32'd5);
        check_value("st_dm_cnt0", 32'(dm_stall_cnt_out), 32'd0);
        if_req_in = 1'b0;
        tick();
        GLOBALRESET = 1'b0;
        tick();
        GLOBALRESET = 1'b1;
        tick();
        run_fetch(32'h0000_0048, 32'h0000_0002, 10);
        check_value("st_if_sat", 32'(if_stall_cnt_out), 32'd7);
        if_req_in = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
